instr_encoder: RTL

Instruction encoder and loader. It is the write-side counterpart of the main control decoder. It accepts symbolic instructions (mnemonic code plus fields) over a valid/ready handshake and encodes each one into the 32-bit MIPS word that the decoder consumes. It then writes the words sequentially into instruction memory. Used by the test/boot path to load VBSME SAD programs without a precompiled hex image.

---
 rtl/instr_encoder_if.sv | 33 +++
 rtl/instr_encoder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Request and instruction-memory bus for the instruction encoder.
// The master side issues symbolic instructions and models the memory;
// the slave side is the encoder itself.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              inValid;
  logic              inReady;
  logic [4:0]        mnem;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              memBusy;
  logic              memWrEn;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memData;
  logic [ADDR_W:0]   wrCount;
  logic              full;
  logic              errFlag;

  modport master (
    output inValid, mnem, rs, rt, rd, shamt, imm, target, memBusy,
    input  inReady, memWrEn, memAddr, memData, wrCount, full, errFlag
  );

  modport slave (
    input  inValid, mnem, rs, rt, rd, shamt, imm, target, memBusy,
    output inReady, memWrEn, memAddr, memData, wrCount, full, errFlag
  );
endinterface

// File: rtl/instr_encoder.sv
// Instruction encoder and loader: turns symbolic instructions into 32-bit
// MIPS words and writes them sequentially into instruction memory through
// a single registered output stage.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           clear,
  instr_encoder_if.slave bus
);

  // Index of the last writable slot; wrPtr never wraps past DEPTH.
  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(DEPTH - 1);

  // Returns {legal, word}; illegal mnemonics give legal=0 and a zero word.
  function automatic logic [32:0] encode(
    input logic [4:0]  mnem, rs, rt, rd, shamt,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [32:0] r;
    r = {1'b1, 32'h0000_0000};
    case (mnem)
      5'd0:  r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h20};   // ADD
      5'd1:  r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h22};   // SUB
      5'd2:  r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h24};   // AND
      5'd3:  r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h25};   // OR
      5'd4:  r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h26};   // XOR
      5'd5:  r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h27};   // NOR
      5'd6:  r[31:0] = {6'h00, rs, rt, rd, 5'd0, 6'h2A};   // SLT
      5'd7:  r[31:0] = {6'h00, 5'd0, rt, rd, shamt, 6'h00}; // SLL
      5'd8:  r[31:0] = {6'h00, 5'd0, rt, rd, shamt, 6'h02}; // SRL
      5'd9:  r[31:0] = {6'h00, rs, 15'd0, 6'h08};           // JR
      5'd10: r[31:0] = {6'h01, rs, 5'd1, imm};              // BGEZ
      5'd11: r[31:0] = {6'h01, rs, 5'd0, imm};              // BLTZ
      5'd12: r[31:0] = {6'h02, target};                     // J
      5'd13: r[31:0] = {6'h03, target};                     // JAL
      5'd14: r[31:0] = {6'h04, rs, rt, imm};                // BEQ
      5'd15: r[31:0] = {6'h05, rs, rt, imm};                // BNE
      5'd16: r[31:0] = {6'h06, rs, 5'd0, imm};              // BLEZ
      5'd17: r[31:0] = {6'h07, rs, 5'd0, imm};              // BGTZ
      5'd18: r[31:0] = {6'h08, rs, rt, imm};                // ADDI
      5'd19: r[31:0] = {6'h0A, rs, rt, imm};                // SLTI
      5'd20: r[31:0] = {6'h0C, rs, rt, imm};                // ANDI
      5'd21: r[31:0] = {6'h0D, rs, rt, imm};                // ORI
      5'd22: r[31:0] = {6'h0E, rs, rt, imm};                // XORI
      5'd23: r[31:0] = {6'h23, rs, rt, imm};                // LW
      5'd24: r[31:0] = {6'h21, rs, rt, imm};                // LH
      5'd25: r[31:0] = {6'h20, rs, rt, imm};                // LB (loadSAD)
      5'd26: r[31:0] = {6'h2B, rs, rt, imm};                // SW
      5'd27: r[31:0] = {6'h29, rs, rt, imm};                // SH
      5'd28: r[31:0] = {6'h28, rs, rt, imm};                // SB (SAD)
      5'd29: r[31:0] = {6'h1C, rs, rt, rd, 5'd0, 6'h02};   // MUL
      default: r = 33'd0;
    endcase
    return r;
  endfunction

  logic              out_valid_q, out_valid_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic              full_q, full_d;
  logic              full_pending_q, full_pending_d;
  logic              err_flag_q, err_flag_d;

  logic [32:0]       enc_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              complete_s;
  logic [ADDR_W:0]   slot_s;

  // Encode the request and derive handshake / write-completion strobes.
  always_comb begin
    enc_s      = encode(bus.mnem, bus.rs, bus.rt, bus.rd, bus.shamt, bus.imm, bus.target);
    in_ready_s = !Rst && !clear && !full_q && !full_pending_q &&
                 (!out_valid_q || !bus.memBusy);
    accept_s   = bus.inValid && in_ready_s;
    complete_s = out_valid_q && !bus.memBusy;
    // Slot a newly accepted word would land in, counting the one in flight.
    slot_s     = wr_ptr_q + {{ADDR_W{1'b0}}, out_valid_q};
  end

  // Next-state logic; clear overrides any accept or completing write.
  always_comb begin
    out_valid_d    = out_valid_q;
    mem_data_d     = mem_data_q;
    wr_ptr_d       = wr_ptr_q;
    full_d         = full_q;
    full_pending_d = full_pending_q;
    err_flag_d     = err_flag_q;
    if (clear) begin
      out_valid_d    = 1'b0;
      wr_ptr_d       = {(ADDR_W+1){1'b0}};
      full_d         = 1'b0;
      full_pending_d = 1'b0;
      err_flag_d     = 1'b0;
    end else begin
      if (complete_s) begin
        out_valid_d = 1'b0;
        wr_ptr_d    = wr_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
        if (wr_ptr_q == LAST_SLOT) begin
          full_d = 1'b1;
        end else begin
          full_d = full_q;
        end
      end else begin
        out_valid_d = out_valid_q;
      end
      if (accept_s) begin
        if (enc_s[32]) begin
          out_valid_d = 1'b1;
          mem_data_d  = enc_s[31:0];
          if (slot_s == LAST_SLOT) begin
            full_pending_d = 1'b1;
          end else begin
            full_pending_d = full_pending_q;
          end
        end else begin
          err_flag_d = 1'b1;
        end
      end else begin
        err_flag_d = err_flag_q;
      end
    end
  end

  // State registers; reset drops any in-flight write completely.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      out_valid_q    <= 1'b0;
      mem_data_q     <= 32'h0000_0000;
      wr_ptr_q       <= {(ADDR_W+1){1'b0}};
      full_q         <= 1'b0;
      full_pending_q <= 1'b0;
      err_flag_q     <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      mem_data_q     <= mem_data_d;
      wr_ptr_q       <= wr_ptr_d;
      full_q         <= full_d;
      full_pending_q <= full_pending_d;
      err_flag_q     <= err_flag_d;
    end
  end

  assign bus.inReady = in_ready_s;
  assign bus.memWrEn = out_valid_q;
  assign bus.memAddr = wr_ptr_q[ADDR_W-1:0];
  assign bus.memData = mem_data_q;
  assign bus.wrCount = wr_ptr_q;
  assign bus.full    = full_q;
  assign bus.errFlag = err_flag_q;

endmodule
